// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly, X = A + B*W, Y = A - B*W, fixed point with FRACTION fractional bits.
// Four register stages, one butterfly per clock, no backpressure; sticky saturation flag.
module fft_butterfly_r2 #(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [WORD_SIZE-1:0] i_ar,
  input  logic [WORD_SIZE-1:0] i_ai,
  input  logic [WORD_SIZE-1:0] i_br,
  input  logic [WORD_SIZE-1:0] i_bi,
  input  logic [WORD_SIZE-1:0] i_wr,
  input  logic [WORD_SIZE-1:0] i_wi,
  input  logic                 i_scale,
  input  logic                 i_clr_ovf,
  output logic                 o_valid,
  output logic [WORD_SIZE-1:0] o_xr,
  output logic [WORD_SIZE-1:0] o_xi,
  output logic [WORD_SIZE-1:0] o_yr,
  output logic [WORD_SIZE-1:0] o_yi,
  output logic                 o_ovf
);

  localparam int PRW = 2 * WORD_SIZE;      // exact product width
  localparam int PW  = 2 * WORD_SIZE + 1;  // product sum/difference width
  localparam int SW  = WORD_SIZE + 1;      // butterfly sum width

  localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (WORD_SIZE - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
  localparam logic signed [PW-1:0] RND     = (FRACTION > 0) ? (PW'(1) << (FRACTION - 1)) : '0;

  // Returns {saturated, clamped word}; wide enough for every intermediate in this block.
  function automatic logic [WORD_SIZE:0] sat_word(input logic signed [PW-1:0] v);
    logic [WORD_SIZE:0] r;
    if (v > SAT_MAX)
      r = {1'b1, 1'b0, {(WORD_SIZE-1){1'b1}}};
    else if (v < SAT_MIN)
      r = {1'b1, 1'b1, {(WORD_SIZE-1){1'b0}}};
    else
      r = {1'b0, v[WORD_SIZE-1:0]};
    return r;
  endfunction

  // ---------------------------------------------------------------- S1
  logic signed [WORD_SIZE-1:0] s1_ar, s1_ai, s1_br, s1_bi, s1_wr, s1_wi;
  logic                        s1_scale, s1_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
      s1_scale <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_ar    <= i_ar;
      s1_ai    <= i_ai;
      s1_br    <= i_br;
      s1_bi    <= i_bi;
      s1_wr    <= i_wr;
      s1_wi    <= i_wi;
      s1_scale <= i_scale;
      s1_valid <= i_valid;
    end
  end

  // ---------------------------------------------------------------- S2
  logic signed [PRW-1:0]       s2_rr, s2_ii, s2_ri, s2_ir;
  logic signed [WORD_SIZE-1:0] s2_ar, s2_ai;
  logic                        s2_scale, s2_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
      s2_ar    <= '0;
      s2_ai    <= '0;
      s2_scale <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s2_rr    <= PRW'(s1_br) * PRW'(s1_wr);
      s2_ii    <= PRW'(s1_bi) * PRW'(s1_wi);
      s2_ri    <= PRW'(s1_br) * PRW'(s1_wi);
      s2_ir    <= PRW'(s1_bi) * PRW'(s1_wr);
      s2_ar    <= s1_ar;
      s2_ai    <= s1_ai;
      s2_scale <= s1_scale;
      s2_valid <= s1_valid;
    end
  end

  // ---------------------------------------------------------------- S3
  logic signed [PW-1:0] tr_full, ti_full, tr_sh, ti_sh;
  logic [WORD_SIZE:0]   tr_sat, ti_sat;

  always_comb begin
    tr_full = PW'(s2_rr) - PW'(s2_ii);
    ti_full = PW'(s2_ri) + PW'(s2_ir);
    // Round half-up before dropping the fractional product bits.
    tr_sh   = (tr_full + RND) >>> FRACTION;
    ti_sh   = (ti_full + RND) >>> FRACTION;
    tr_sat  = sat_word(tr_sh);
    ti_sat  = sat_word(ti_sh);
  end

  logic signed [WORD_SIZE-1:0] s3_tr, s3_ti, s3_ar, s3_ai;
  logic                        s3_scale, s3_valid, s3_sat;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s3_tr    <= '0;
      s3_ti    <= '0;
      s3_ar    <= '0;
      s3_ai    <= '0;
      s3_scale <= 1'b0;
      s3_valid <= 1'b0;
      s3_sat   <= 1'b0;
    end else begin
      s3_tr    <= tr_sat[WORD_SIZE-1:0];
      s3_ti    <= ti_sat[WORD_SIZE-1:0];
      s3_ar    <= s2_ar;
      s3_ai    <= s2_ai;
      s3_scale <= s2_scale;
      s3_valid <= s2_valid;
      s3_sat   <= tr_sat[WORD_SIZE] | ti_sat[WORD_SIZE];
    end
  end

  // ---------------------------------------------------------------- S4
  logic signed [SW-1:0]  xr_s, xi_s, yr_s, yi_s;
  logic [WORD_SIZE:0]    xr_c, xi_c, yr_c, yi_c;
  logic [WORD_SIZE-1:0]  xr_n, xi_n, yr_n, yi_n;
  logic                  sat4;

  always_comb begin
    xr_s = SW'(s3_ar) + SW'(s3_tr);
    xi_s = SW'(s3_ai) + SW'(s3_ti);
    yr_s = SW'(s3_ar) - SW'(s3_tr);
    yi_s = SW'(s3_ai) - SW'(s3_ti);
    xr_c = sat_word(PW'(xr_s));
    xi_c = sat_word(PW'(xi_s));
    yr_c = sat_word(PW'(yr_s));
    yi_c = sat_word(PW'(yi_s));
    // Halving a WORD_SIZE+1 sum always lands back inside WORD_SIZE.
    if (s3_scale) begin
      xr_n = xr_s[WORD_SIZE:1];
      xi_n = xi_s[WORD_SIZE:1];
      yr_n = yr_s[WORD_SIZE:1];
      yi_n = yi_s[WORD_SIZE:1];
      sat4 = 1'b0;
    end else begin
      xr_n = xr_c[WORD_SIZE-1:0];
      xi_n = xi_c[WORD_SIZE-1:0];
      yr_n = yr_c[WORD_SIZE-1:0];
      yi_n = yi_c[WORD_SIZE-1:0];
      sat4 = xr_c[WORD_SIZE] | xi_c[WORD_SIZE] | yr_c[WORD_SIZE] | yi_c[WORD_SIZE];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_xr    <= '0;
      o_xi    <= '0;
      o_yr    <= '0;
      o_yi    <= '0;
    end else begin
      o_valid <= s3_valid;
      if (s3_valid) begin
        o_xr <= xr_n;
        o_xi <= xi_n;
        o_yr <= yr_n;
        o_yi <= yi_n;
      end
    end
  end

  // Clear wins over a same-cycle set; invalid slots never touch the flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      o_ovf <= 1'b0;
    else if (i_clr_ovf)
      o_ovf <= 1'b0;
    else if (s3_valid && (s3_sat || sat4))
      o_ovf <= 1'b1;
  end

endmodule
